// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, one bit per cycle over 32 cycles.
module ex_muldiv #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] rd1_data_i,
    input  logic [DATA_WIDTH-1:0] rd2_data_i,
    input  logic [2:0]            ins_func3_i,
    input  logic [RD_WIDTH-1:0]   rd_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [RD_WIDTH-1:0]   rd_o
);
    localparam int unsigned W = DATA_WIDTH;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e              state_q;
    logic [5:0]          cnt_q;
    logic [2:0]          func3_q;
    logic [RD_WIDTH-1:0] rd_q;
    logic                neg_q;
    logic [W-1:0]        opnd_q;   // multiplicand or divisor magnitude
    logic [2*W-1:0]      acc_q;    // {hi, lo}: product, or {remainder, quotient}
    logic                done_q;
    logic [W-1:0]        result_q;
    logic [RD_WIDTH-1:0] rd_out_q;

    // Operand decode in IDLE
    logic         is_div, signed_a, signed_b, a_neg, b_neg, neg_d;
    logic [W-1:0] a_mag, b_mag;
    logic         div_zero, div_ovf;
    logic [W-1:0] special_res;

    always_comb begin
        is_div   = ins_func3_i[2];
        signed_a = (ins_func3_i == 3'd1) || (ins_func3_i == 3'd2) ||
                   (ins_func3_i == 3'd4) || (ins_func3_i == 3'd6);
        signed_b = (ins_func3_i == 3'd1) || (ins_func3_i == 3'd4) || (ins_func3_i == 3'd6);
        a_neg    = signed_a && rd1_data_i[W-1];
        b_neg    = signed_b && rd2_data_i[W-1];
        a_mag    = a_neg ? (~rd1_data_i + 1'b1) : rd1_data_i;
        b_mag    = b_neg ? (~rd2_data_i + 1'b1) : rd2_data_i;
        // Remainder follows dividend sign; quotient and product follow sign xor.
        neg_d    = (is_div && ins_func3_i[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div && (rd2_data_i == '0);
        div_ovf  = is_div && !ins_func3_i[0] && (rd1_data_i == {1'b1, {(W-1){1'b0}}}) &&
                   (rd2_data_i == '1);
        special_res = '1;
        if (div_zero) begin
            special_res = ins_func3_i[1] ? rd1_data_i : '1;
        end else if (div_ovf) begin
            special_res = ins_func3_i[1] ? '0 : {1'b1, {(W-1){1'b0}}};
        end
    end

    // One iteration of shift-add multiply or restoring divide
    logic [W:0]     mul_sum;
    logic [W+1:0]   div_diff;
    logic [2*W-1:0] acc_nxt;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, final_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_diff = {1'b0, acc_q[2*W-1:W], acc_q[W-1]} - {2'b00, opnd_q};
        if (!func3_q[2]) begin
            acc_nxt = {mul_sum, acc_q[W-1:1]};
        end else if (!div_diff[W+1]) begin
            acc_nxt = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
            acc_nxt = {acc_q[2*W-2:W-1], acc_q[W-2:0], 1'b0};
        end
        prod_fix = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
        quo_fix  = neg_q ? (~acc_nxt[W-1:0] + 1'b1) : acc_nxt[W-1:0];
        rem_fix  = neg_q ? (~acc_nxt[2*W-1:W] + 1'b1) : acc_nxt[2*W-1:W];
        if (func3_q[2]) begin
            final_res = func3_q[1] ? rem_fix : quo_fix;
        end else if (func3_q == 3'd0) begin
            final_res = acc_nxt[W-1:0];
        end else begin
            final_res = prod_fix[2*W-1:W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            func3_q  <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else if (flush_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        func3_q <= ins_func3_i;
                        rd_q    <= rd_i;
                        neg_q   <= neg_d;
                        cnt_q   <= '0;
                        opnd_q  <= is_div ? b_mag : a_mag;
                        acc_q   <= {{W{1'b0}}, (is_div ? a_mag : b_mag)};
                        if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            rd_out_q <= rd_i;
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    acc_q <= acc_nxt;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        result_q <= final_res;
                        rd_out_q <= rd_q;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign stall_o  = ((state_q == StIdle) && start_i && !flush_i) || (state_q == StCalc);
    assign done_o   = done_q;
    assign result_o = result_q;
    assign rd_o     = rd_out_q;
endmodule
